fetch_header_unit: RTL and testbench

- Instruction-fetch front end that produces the instruction stream consumed by the control unit's decode stage.
- Issues sequential word fetches to a synchronous instruction memory and buffers the returned words in a small prefetch FIFO.
- Presents each word to decode with its 10-bit header (Instr[31:22]) and its PC.
- Absorbs decode stalls, and flushes on branch redirect.

---
 rtl/fetch_header_unit_if.sv | 26 ++
 rtl/fetch_header_unit.sv | 87 ++++++++
 tb/tb_fetch_header_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_header_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response plus the decode-side stream.
// master = fetch unit, slave = memory/decode environment.
interface fetch_header_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [9:0]        inst_header;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_header, inst_pc,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_header, inst_pc,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_header_unit.sv
// Sequential instruction fetch into a small prefetch FIFO; presents word, header and PC to decode.
// Redirect flushes the FIFO and drops the response to any request issued before it.
module fetch_header_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input logic                  clk,
  input logic                  reset,
  fetch_header_unit_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [PTR_W:0]    count;
  logic              inflight;
  logic              killed;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] tagPc;
  logic [31:0]       wordMem [DEPTH];
  logic [ADDR_W-1:0] pcMem   [DEPTH];

  logic              instValid;
  logic              pop;
  logic              push;
  logic              issue;
  logic [PTR_W+1:0]  reserved;
  logic [31:0]       headWord;
  logic [ADDR_W-1:0] headPc;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    instValid = ~reset & (count != '0);
    pop       = instValid & ~bus.stall;
    push      = inflight & ~killed;
    // Slots already spoken for: buffered entries plus the response still in flight.
    reserved  = {1'b0, count} + (PTR_W+2)'(inflight) - (PTR_W+2)'(pop);
    issue     = ~reset & ~bus.redirect & (reserved < (PTR_W+2)'(DEPTH));
    headWord  = instValid ? wordMem[rdPtr] : '0;
    headPc    = instValid ? pcMem[rdPtr]   : '0;
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetchPc;
  assign bus.inst_valid  = instValid;
  assign bus.inst        = headWord;
  assign bus.inst_header = headWord[31:22];
  assign bus.inst_pc     = headPc;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc  <= RESET_PC;
      tagPc    <= '0;
      inflight <= 1'b0;
      killed   <= 1'b0;
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      inflight <= issue;
      killed   <= bus.redirect;
      if (issue) begin
        tagPc   <= fetchPc;
        fetchPc <= fetchPc + ADDR_W'(4);
      end
      if (bus.redirect) begin
        fetchPc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        count   <= '0;
        rdPtr   <= '0;
        wrPtr   <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      wordMem[wrPtr] <= bus.imem_rdata;
      pcMem[wrPtr]   <= tagPc;
    end
  end
endmodule

// File: tb/tb_fetch_header_unit.sv
// Directed bench for fetch_header_unit: synchronous memory model, pop monitor, per-scenario tasks.
module tb_fetch_header_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] popPcs[$];
  logic [31:0] popInsts[$];

  fetch_header_unit_if #(.ADDR_W(32)) bus ();

  fetch_header_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Word at address A is A, except two header test words at 0x8 and 0xC.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'h0080_0000;
      32'h0000_000C: return 32'h0480_0000;
      default:       return a;
    endcase
  endfunction

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? memWord(bus.imem_addr) : 32'hDEAD_BEEF;

  always @(negedge clk)
    if (!reset && !bus.redirect && bus.inst_valid && !bus.stall) begin
      popPcs.push_back(bus.inst_pc);
      popInsts.push_back(bus.inst);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expHead(input string name, input logic [31:0] pc, input logic [31:0] word);
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== pc || bus.inst !== word) begin
      errors++;
      $display("FAIL %s: valid=%b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
               name, bus.inst_valid, bus.inst_pc, bus.inst, pc, word);
    end
  endtask

  task automatic expReq(input string name, input logic req, input logic [31:0] addr);
    checks++;
    if (bus.imem_req !== req || (req && bus.imem_addr !== addr)) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h, expected req=%b addr=%h",
               name, bus.imem_req, bus.imem_addr, req, addr);
    end
  endtask

  task automatic expInvalid(input string name);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: inst_valid=%b, expected 0", name, bus.inst_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.inst !== 32'h0 ||
        bus.inst_header !== 10'h000 || bus.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b req=%b inst=%h hdr=%h pc=%h, expected all 0",
               bus.inst_valid, bus.imem_req, bus.inst, bus.inst_header, bus.inst_pc);
    end
    reset = 1'b0;
    popPcs.delete();
    popInsts.delete();
    #1;
  endtask

  // Cycle 1 is the first cycle with reset low.
  task automatic test_fetch();
    expReq("fetch_c1_req", 1'b1, 32'h0);
    expInvalid("fetch_c1_valid");
    step();
    expReq("fetch_c2_req", 1'b1, 32'h4);
    expInvalid("fetch_c2_valid");
    step();
    expHead("fetch_c3_head", 32'h0, 32'h0);
    checks++;
    if (bus.inst_header !== 10'h000) begin
      errors++;
      $display("FAIL fetch_c3_header: got %h expected 000", bus.inst_header);
    end
    step();
    expHead("fetch_c4_head", 32'h4, 32'h4);
    step();
    expHead("header_pc8", 32'h8, 32'h0080_0000);
    checks++;
    if (bus.inst_header !== 10'b0000000010) begin
      errors++;
      $display("FAIL header_pc8_bits: got %b expected 0000000010", bus.inst_header);
    end
    step();
    expHead("header_pcC", 32'hC, 32'h0480_0000);
    checks++;
    if (bus.inst_header !== 10'b0000010010) begin
      errors++;
      $display("FAIL header_pcC_bits: got %b expected 0000010010", bus.inst_header);
    end
  endtask

  // Stall from cycle 7: two more requests fit (entries+inflight reach 4), then none.
  task automatic test_stall();
    step();
    bus.stall = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      expHead($sformatf("stall_head_k%0d", k), 32'h10, 32'h10);
      checks++;
      if (bus.imem_req !== (k < 2)) begin
        errors++;
        $display("FAIL stall_req_k%0d: req=%b expected %b", k, bus.imem_req, (k < 2));
      end
      step();
    end
    bus.stall = 1'b0;
    #1;
    for (int j = 0; j < 8; j++) step();
    checks++;
    if (popPcs.size() != 12) begin
      errors++;
      $display("FAIL stall_pop_count: got %0d expected 12", popPcs.size());
    end
    for (int i = 0; i < popPcs.size() && i < 12; i++) begin
      checks++;
      if (popPcs[i] !== 32'(i * 4) || popInsts[i] !== memWord(32'(i * 4))) begin
        errors++;
        $display("FAIL stall_seq_%0d: pc=%h inst=%h expected pc=%h inst=%h",
                 i, popPcs[i], popInsts[i], 32'(i * 4), memWord(32'(i * 4)));
      end
    end
  endtask

  // Build 3 buffered + 1 in flight with a two-cycle stall, then redirect to 0x100.
  task automatic test_redirect();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    step();
    step();
    bus.stall = 1'b1;
    step();
    step();
    bus.stall = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    expReq("redir_R_req", 1'b0, 32'h0);
    step();
    bus.redirect = 1'b0;
    popPcs.delete();
    popInsts.delete();
    #1;
    expReq("redir_R1_req", 1'b1, 32'h100);
    expInvalid("redir_R1_valid");
    step();
    expReq("redir_R2_req", 1'b1, 32'h104);
    expInvalid("redir_R2_valid");
    step();
    expHead("redir_R3_head", 32'h100, 32'h100);
    step();
    step();
    step();
    checks++;
    if (popPcs.size() != 3 || popPcs[0] !== 32'h100 || popPcs[1] !== 32'h104 ||
        popPcs[2] !== 32'h108) begin
      errors++;
      $display("FAIL redir_seq: got %0d pops first=%h expected 3 pops 100,104,108",
               popPcs.size(), (popPcs.size() > 0) ? popPcs[0] : 32'hX);
    end
  endtask

  // Redirect while stalled; misaligned target 0x205 becomes 0x204.
  task automatic test_redirect_stall();
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h205;
    #1;
    expReq("rstall_R_req", 1'b0, 32'h0);
    step();
    bus.redirect = 1'b0;
    #1;
    expReq("rstall_R1_req", 1'b1, 32'h204);
    expInvalid("rstall_R1_valid");
    step();
    step();
    expHead("rstall_R3_head", 32'h204, 32'h204);
    step();
    expHead("rstall_R4_held", 32'h204, 32'h204);
    popPcs.delete();
    popInsts.delete();
    bus.stall = 1'b0;
    #1;
    step();
    step();
    checks++;
    if (popPcs.size() != 2 || popPcs[0] !== 32'h204 || popPcs[1] !== 32'h208) begin
      errors++;
      $display("FAIL rstall_seq: got %0d pops first=%h expected 204,208",
               popPcs.size(), (popPcs.size() > 0) ? popPcs[0] : 32'hX);
    end
  endtask

  // Reset mid-stream with a simultaneous redirect: reset wins, fetch restarts at 0.
  task automatic test_reset_mid();
    reset = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    #1;
    expInvalid("rmid_during_valid");
    expReq("rmid_during_req", 1'b0, 32'h0);
    checks++;
    if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL rmid_during_zero: inst=%h pc=%h expected 0", bus.inst, bus.inst_pc);
    end
    step();
    reset = 1'b0;
    bus.redirect = 1'b0;
    #1;
    expInvalid("rmid_next_valid");
    expReq("rmid_next_req", 1'b1, 32'h0);
    step();
    step();
    expHead("rmid_restart_head", 32'h0, 32'h0);
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    #1;
    expReq("wrap_R1_req", 1'b1, 32'hFFFF_FFFC);
    step();
    expReq("wrap_R2_req", 1'b1, 32'h0);
    step();
    expHead("wrap_head_top", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    checks++;
    if (bus.inst_header !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_header: got %h expected 3ff", bus.inst_header);
    end
    step();
    expHead("wrap_head_zero", 32'h0, 32'h0);
    step();
    expHead("wrap_head_four", 32'h4, 32'h4);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
